dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Sequencer and two-port arbiter for the word-wide data memory. It accepts byte, halfword and word load/store requests from the core load/store port (A) and the loader/debug port (B), and arbitrates between them round-robin. It converts each request into word-wide memory cycles, using read-modify-write for sub-word stores, and returns sign- or zero-extended load data with a one-cycle ack. It sits between the requesters and the memory's addr/write_data/memwrite/memread/read_data pins.

## Interface
- ADDR_W, 10: word-address width driven to memory.
- DEPTH, 1001: number of valid words; word address >= DEPTH is an error.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- a_req, b_req  in  1  request; held with fields stable until the matching ack.
- a_we, b_we  in  1  1 = store, 0 = load.
- a_size, b_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- a_uns, b_uns  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- a_addr, b_addr  in  ADDR_W+2  byte address.
- a_wdata, b_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- a_ack, b_ack  out  1  one-cycle completion pulse.
- a_err, b_err  out  1  valid with ack: misaligned, illegal size or out of range.
- a_rdata, b_rdata  out  32  extended load data, valid in the ack cycle; 0 for stores and errors.
- busy  out  1  state != IDLE.
- mem_addr  out  ADDR_W  word address = latched addr[ADDR_W+1:2].
- mem_wdata  out  32  word or merged word to write.
- mem_we  out  1  write strobe, asserted only in WR.
- mem_re  out  1  read strobe, asserted only in RD.
- mem_rdata  in  32  memory read data, valid the cycle after mem_re.

## Operation
- States: IDLE, RD, RDW, WR, RESP. Every output is decoded from the state register and the latched request registers.
- IDLE: if a_req or b_req, grant one port and latch its we/size/uns/addr/wdata.
- Arbitration: with one request, grant it. With both, grant the port not served last (flag `last_b`; reset value 0, so B wins the first tie).
- Checks run at grant:
  - Half with addr[0]=1 is an error.
  - Word with addr[1:0]!=0 is an error.
  - size=11 is an error.
  - Word address >= DEPTH is an error.
  - Any error goes to RESP with err=1. No memory strobe is issued.
- Transitions from IDLE on a legal request:
  - Word store goes to WR, with mem_wdata = wdata.
  - Load, byte store or half store goes to RD.
- RD: mem_re=1, then go to RDW.
- RDW: capture mem_rdata into buf.
  - Load goes to RESP.
  - Sub-word store goes to WR.
- Merge for sub-word stores:
  - Byte store replaces buf lane addr[1:0] (lane 0 = [7:0]) with wdata[7:0].
  - Half store replaces [15:0] if addr[1]=0, [31:16] if addr[1]=1, with wdata[15:0].
  - All other bits of buf are kept.
- WR: mem_we=1, mem_wdata = merged word (or wdata for a word store), then go to RESP.
- RESP: raise the granted port's ack for one cycle, drive rdata/err, update last_b, then go to IDLE.
- Load extraction: select the lane from buf by addr[1:0] / addr[1]. Bit 7 or bit 15 is replicated upward unless uns=1.
- The non-granted port's ack, err and rdata stay 0 throughout.

## Timing
- Cycle 0 is the IDLE cycle in which the request is sampled. Ack arrives in:
  - Error: cycle 1.
  - Word store: cycle 2.
  - Load: cycle 3.
  - Byte/half store: cycle 4.
- Minimum spacing between two grants is 1 IDLE cycle. A requester must deassert req, or present a new request, in the cycle after its ack.
- A request arriving while busy waits. It is evaluated in the next IDLE cycle together with any other pending request.
- Reset outputs: state IDLE, busy=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, all ack/err/rdata=0, last_b=0.
- Reset mid-operation: the operation is aborted with no ack. Reset sampled in WR still lets that WR cycle's write complete, and no further strobes follow.
- At most one of mem_we/mem_re is high in any cycle.
- Each read-modify-write uses the same mem_addr in RD and WR.

## Test plan
- Word store then load, port A: SW 0xDEADBEEF at byte 0x010 -> ack at cycle 2 with one mem_we and mem_addr=4. LW 0x010 -> ack at cycle 3, a_rdata=0xDEADBEEF.
- Sub-word RMW: word 0x11223344 at 0x020, SB 0xAA at 0x022 -> mem_we data 0x11AA3344, ack at cycle 4. LB 0x022 -> 0xFFFFFFAA. LBU -> 0x000000AA. LH 0x022 -> 0x000011AA.
- Errors: LH 0x021, SW 0x012, size=11, and LW at word 1001 (byte 0xFA4) -> err+ack at cycle 1 each, no mem_re/mem_we, rdata=0.
- Arbitration: a_req and b_req held together for 4 requests each -> first grant B (last_b=0 after reset), then strict alternation B,A,B,A… No ack is lost, and neither port waits more than one operation.
- Reset mid-op: assert rst in RDW of an SB -> no mem_we, no ack, busy=0 next cycle. A subsequent LW returns the pre-store word.
- Back-to-back loads on A with B idle: ack spacing is exactly 4 cycles.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Round-robin two-port sequencer for a word-wide data memory.
// Sub-word stores are read-modify-write cycles. Load data is sign- or zero-extended and returned with a one-cycle ack.
module dmem_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [1:0]        a_size,
    input  logic              a_uns,
    input  logic [ADDR_W+1:0] a_addr,
    input  logic [31:0]       a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [31:0]       a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [1:0]        b_size,
    input  logic              b_uns,
    input  logic [ADDR_W+1:0] b_addr,
    input  logic [31:0]       b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [31:0]       b_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, RDW, WR, RESP} state_t;

    state_t            state;
    logic              last_b;
    logic              gnt_b;
    logic              we;
    logic              uns;
    logic              err;
    logic [1:0]        size;
    logic [ADDR_W+1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rd_word;

    logic              sel_b;
    logic              sel_we;
    logic              sel_uns;
    logic              sel_err;
    logic [1:0]        sel_size;
    logic [ADDR_W+1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [31:0]       ld_word;

    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] sz, input logic [1:0] lo);
        logic [31:0] r;
        r = old;
        if (sz == 2'b00) begin
            case (lo)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end else if (sz == 2'b01) begin
            if (lo[1]) r[31:16] = wd[15:0];
            else       r[15:0]  = wd[15:0];
        end else begin
            r = wd;
        end
        return r;
    endfunction

    function automatic logic [31:0] extract_word(input logic [31:0] w, input logic [1:0] sz,
                                                 input logic [1:0] lo, input logic zx);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   return {{24{b[7] & ~zx}}, b};
            2'b01:   return {{16{h[15] & ~zx}}, h};
            default: return w;
        endcase
    endfunction

    // Grant selection: on a tie, serve whichever port was not served last.
    always_comb begin
        sel_b     = b_req && (!a_req || !last_b);
        sel_we    = sel_b ? b_we    : a_we;
        sel_size  = sel_b ? b_size  : a_size;
        sel_uns   = sel_b ? b_uns   : a_uns;
        sel_addr  = sel_b ? b_addr  : a_addr;
        sel_wdata = sel_b ? b_wdata : a_wdata;
        sel_err   = (sel_size == 2'b11)
                 || (sel_size == 2'b01 && sel_addr[0])
                 || (sel_size == 2'b10 && sel_addr[1:0] != 2'b00)
                 || (int'(sel_addr[ADDR_W+1:2]) >= DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last_b <= 1'b0;
            gnt_b  <= 1'b0;
            we     <= 1'b0;
            uns    <= 1'b0;
            err    <= 1'b0;
            size   <= 2'b00;
            addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        gnt_b <= sel_b;
                        we    <= sel_we;
                        size  <= sel_size;
                        uns   <= sel_uns;
                        addr  <= sel_addr;
                        wdata <= sel_wdata;
                        err   <= sel_err;
                        if (sel_err)                         state <= RESP;
                        else if (sel_we && sel_size == 2'b10) state <= WR;
                        else                                 state <= RD;
                    end
                end
                RD:  state <= RDW;
                RDW: begin
                    rd_word <= mem_rdata;
                    state   <= we ? WR : RESP;
                end
                WR:  state <= RESP;
                RESP: begin
                    last_b <= gnt_b;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ld_word   = extract_word(rd_word, size, addr[1:0], uns);
    assign busy      = (state != IDLE);
    assign mem_re    = (state == RD);
    assign mem_we    = (state == WR);
    assign mem_addr  = addr[ADDR_W+1:2];
    assign mem_wdata = mem_we ? merge_word(rd_word, wdata, size, addr[1:0]) : 32'd0;

    assign a_ack   = (state == RESP) && !gnt_b;
    assign b_ack   = (state == RESP) && gnt_b;
    assign a_err   = a_ack && err;
    assign b_err   = b_ack && err;
    assign a_rdata = (a_ack && !err && !we) ? ld_word : 32'd0;
    assign b_rdata = (b_ack && !err && !we) ? ld_word : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized bench for dmem_ctrl: a byte-addressed reference memory predicts load data, latency,
// strobe counts and write data; directed cases cover errors, reset abort and arbitration.
module tb_dmem_ctrl;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 0, a_we = 0, a_uns = 0, b_req = 0, b_we = 0, b_uns = 0;
    logic [1:0]  a_size = 0, b_size = 0;
    logic [11:0] a_addr = 0, b_addr = 0;
    logic [31:0] a_wdata = 0, b_wdata = 0;
    logic        a_ack, a_err, b_ack, b_err, busy, mem_we, mem_re;
    logic [31:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic [9:0]  mem_addr;

    logic [31:0] ram [0:1023];
    logic        init_mem = 1'b1;
    logic [7:0]  ref_bytes [0:4095];
    int          cyc = 0;
    int          total = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_uns(a_uns), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_uns(b_uns), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] pat(input int i);
        return 32'(i) * 32'h9E3779B1 + 32'h13579BDF;
    endfunction

    // Memory the controller talks to: one-cycle read latency.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) ram[i] <= pat(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [11:0] ad, input logic [1:0] sz, input bit zx);
        logic [31:0] v;
        int nb;
        nb = 1 << sz;
        v = 0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[int'(ad) + i]) << (8 * i));
        if (!zx && sz == 2'b00 && v[7])  v = v | 32'hFFFFFF00;
        if (!zx && sz == 2'b01 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic ref_store(input logic [11:0] ad, input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] t;
        for (int i = 0; i < (1 << sz); i++) begin
            t = wd >> (8 * i);
            ref_bytes[int'(ad) + i] = t[7:0];
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [9:0] wa);
        int b;
        b = 4 * int'(wa);
        return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
    endfunction

    task automatic set_port(input bit p, input bit req, input bit we, input logic [1:0] sz,
                            input bit zx, input logic [11:0] ad, input logic [31:0] wd);
        if (p) begin
            b_req = req; b_we = we; b_size = sz; b_uns = zx; b_addr = ad; b_wdata = wd;
        end else begin
            a_req = req; a_we = we; a_size = sz; a_uns = zx; a_addr = ad; a_wdata = wd;
        end
    endtask

    task automatic do_op(input bit p, input bit we, input logic [1:0] sz, input bit zx,
                         input logic [11:0] ad, input logic [31:0] wd, output int ack_at);
        bit          e, got;
        int          nre, nwe, lat_exp;
        logic [31:0] exp_rd, exp_word;
        logic [9:0]  wa;
        wa = ad[11:2];
        e = (sz == 2'b11) || (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00)
            || (int'(wa) >= DEPTH);
        exp_rd = 0;
        exp_word = 0;
        if (!e && !we) exp_rd = ref_load(ad, sz, zx);
        if (!e && we) begin
            ref_store(ad, sz, wd);
            exp_word = ref_word(wa);
        end
        lat_exp = e ? 1 : (we && sz == 2'b10) ? 2 : we ? 4 : 3;
        @(negedge clk);
        set_port(p, 1, we, sz, zx, ad, wd);
        got = 0; nre = 0; nwe = 0; ack_at = -1;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge clk);
            chk("strobe_excl", 32'(mem_re & mem_we), 0);
            if (mem_re) begin nre++; chk("re_addr", 32'(mem_addr), 32'(wa)); end
            if (mem_we) begin
                nwe++;
                chk("we_addr", 32'(mem_addr), 32'(wa));
                chk("we_data", mem_wdata, exp_word);
            end
            chk("other_ack", 32'(p ? a_ack : b_ack), 0);
            if (p ? b_ack : a_ack) begin
                got = 1;
                ack_at = cyc;
                chk("rdata", p ? b_rdata : a_rdata, exp_rd);
                chk("err", 32'(p ? b_err : a_err), 32'(e));
                chk("latency", n, lat_exp);
                chk("n_re", nre, (!e && !(we && sz == 2'b10)) ? 1 : 0);
                chk("n_we", nwe, (!e && we) ? 1 : 0);
                set_port(p, 0, 0, 2'b00, 0, 12'h000, 32'h0);
            end
        end
        chk("ack_seen", 32'(got), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t1, t2, t3, k, ai, bi, pa, pb;
        bit          lastb, g;
        bit          exp_ord [8];
        logic [31:0] w;
        logic [11:0] ad;
        logic [1:0]  sz;

        for (int i = 0; i < 4096; i++) begin
            w = pat(i / 4) >> (8 * (i % 4));
            ref_bytes[i] = w[7:0];
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_a_ack", 32'(a_ack), 0);
        chk("rst_b_ack", 32'(b_ack), 0);
        chk("rst_a_err", 32'(a_err), 0);
        chk("rst_b_err", 32'(b_err), 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        init_mem = 1'b0;
        rst = 1'b0;

        do_op(0, 1, 2'b10, 0, 12'h010, 32'hDEADBEEF, t1);
        do_op(0, 0, 2'b10, 0, 12'h010, 32'h0, t1);

        do_op(0, 1, 2'b10, 0, 12'h020, 32'h11223344, t1);
        do_op(0, 1, 2'b00, 0, 12'h022, 32'h000000AA, t1);
        do_op(0, 0, 2'b00, 0, 12'h022, 32'h0, t1);
        do_op(0, 0, 2'b00, 1, 12'h022, 32'h0, t1);
        do_op(1, 0, 2'b01, 0, 12'h022, 32'h0, t1);
        do_op(1, 1, 2'b01, 0, 12'h026, 32'h0000BEEF, t1);
        do_op(1, 0, 2'b01, 0, 12'h026, 32'h0, t1);

        do_op(0, 0, 2'b01, 0, 12'h021, 32'h0, t1);
        do_op(0, 1, 2'b10, 0, 12'h012, 32'h12345678, t1);
        do_op(1, 0, 2'b11, 0, 12'h030, 32'h0, t1);
        do_op(0, 0, 2'b10, 0, 12'hFA4, 32'h0, t1);
        do_op(1, 1, 2'b00, 0, 12'hFFF, 32'h5A, t1);

        do_op(0, 0, 2'b10, 0, 12'h040, 32'h0, t1);
        do_op(0, 0, 2'b00, 0, 12'h045, 32'h0, t2);
        do_op(0, 0, 2'b01, 1, 12'h04A, 32'h0, t3);
        chk("b2b_spacing1", t2 - t1, 4);
        chk("b2b_spacing2", t3 - t2, 4);

        for (int i = 0; i < 80; i++) begin
            sz = 2'($urandom_range(0, 3));
            ad = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(12'hF90, 12'hFFF))
                                             : 12'($urandom_range(0, 12'h3FF));
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 2'b01) ad[0] = 1'b0;
                if (sz == 2'b10) ad[1:0] = 2'b00;
            end
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  ad, $urandom, t1);
        end

        // Abort a byte store in its read-capture cycle; the word must be left untouched.
        do_op(0, 1, 2'b10, 0, 12'h024, 32'hCAFEF00D, t1);
        @(negedge clk);
        set_port(0, 1, 1, 2'b00, 0, 12'h025, 32'h00000055);
        @(negedge clk);
        chk("rst_seq_re", 32'(mem_re), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_port(0, 0, 0, 2'b00, 0, 12'h000, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_busy", 32'(busy), 0);
            chk("abort_we", 32'(mem_we), 0);
            chk("abort_ack", 32'(a_ack), 0);
        end
        do_op(0, 0, 2'b10, 0, 12'h024, 32'h0, t1);

        // Both ports held: expected order from the round-robin rule, B wins the first tie.
        lastb = 0; pa = 4; pb = 4;
        for (int i = 0; i < 8; i++) begin
            if (pa > 0 && pb > 0) g = !lastb;
            else                  g = (pb > 0);
            exp_ord[i] = g;
            lastb = g;
            if (g) pb--; else pa--;
        end
        k = 0; ai = 0; bi = 0;
        @(negedge clk);
        set_port(0, 1, 0, 2'b10, 0, 12'h100, 32'h0);
        set_port(1, 1, 0, 2'b01, 0, 12'h200, 32'h0);
        for (int n = 0; n < 80 && k < 8; n++) begin
            @(negedge clk);
            chk("arb_both", 32'(a_ack & b_ack), 0);
            if (a_ack) begin
                chk("arb_order", 32'(0), 32'(exp_ord[k]));
                chk("arb_a_rdata", a_rdata, ref_load(12'h100 + 12'(4 * ai), 2'b10, 0));
                ai++; k++;
                if (ai < 4) set_port(0, 1, 0, 2'b10, 0, 12'h100 + 12'(4 * ai), 32'h0);
                else        set_port(0, 0, 0, 2'b00, 0, 12'h000, 32'h0);
            end else if (b_ack) begin
                chk("arb_order", 32'(1), 32'(exp_ord[k]));
                chk("arb_b_rdata", b_rdata, ref_load(12'h200 + 12'(2 * bi), 2'b01, 0));
                bi++; k++;
                if (bi < 4) set_port(1, 1, 0, 2'b01, 0, 12'h200 + 12'(2 * bi), 32'h0);
                else        set_port(1, 0, 0, 2'b00, 0, 12'h000, 32'h0);
            end
        end
        chk("arb_count", k, 8);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, n_bad);
        $finish;
    end
endmodule
